pipe_stall_ctrl: RTL and testbench

Pipeline stall controller for the five-stage scalar core. Merges stall requests from ID (load-use and generic), the multi-cycle multiply/divide unit (MDU) in EX, and the data-SRAM handshake in MEM into the single `StallBus` vector consumed by PC, IF, ID, EX, MEM and WB. It also sequences the MDU: it counts the unit's fixed latency and tells EX when the result is valid. It flags a data-SRAM wait that exceeds a bound.

---
 rtl/pipe_stall_ctrl_pkg.sv | 14 +
 rtl/pipe_stall_ctrl_mdu_seq.sv | 35 +++
 rtl/pipe_stall_ctrl.sv | 68 ++++++
 tb/tb_pipe_stall_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: stall-bus type, per-source stall vectors and MDU state encodings.
package pipe_stall_ctrl_pkg;
  typedef logic [5:0] stall_bus_t;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam stall_bus_t STALL_ID_VEC = 6'b000111;
  localparam stall_bus_t STALL_MDU_VEC = 6'b001111;
  localparam stall_bus_t STALL_MEM_VEC = 6'b011111;
  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;
endpackage

// File: rtl/pipe_stall_ctrl_mdu_seq.sv
// mdu_seq: sequences the fixed-latency MDU and holds DONE until EX is released.
module mdu_seq
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 33
) (
  input  logic clk,
  input  logic rst,
  input  logic mdu_start,
  input  logic ex_stall,
  output logic mdu_busy,
  output logic mdu_done
);
  mdu_state_t state, state_nx;
  logic [7:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == MDU_IDLE && mdu_start) ? 8'(MDU_LAT - 2) :
               (state == MDU_BUSY && cnt != '0) ? cnt - 8'd1 : cnt;
    end
  end
  // DONE holds while EX is frozen by a MEM wait so the result is not lost
  always_comb begin
    state_nx = state;
    state_nx = (state == MDU_IDLE) ? (mdu_start ? MDU_BUSY : MDU_IDLE) :
               (state == MDU_BUSY) ? (cnt == '0 ? MDU_DONE : MDU_BUSY) :
               (ex_stall == STOP) ? MDU_DONE : MDU_IDLE;
  end
  assign mdu_busy = ~rst & ((state == MDU_BUSY) | (state == MDU_IDLE & mdu_start));
  assign mdu_done = ~rst & (state == MDU_DONE);
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges ID/MDU/MEM stall requests, sequences the MDU, watches MEM waits.
// Define STALL_PERF_EN to add per-source stall-cycle counters.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MDU_LAT     = 33,
  parameter int MEM_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_for_load,
  input  logic        mdu_start,
  input  logic        mem_req,
  input  logic        mem_ready,
  output stall_bus_t  stall,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic        mem_timeout
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] perf_id_cyc,
  output logic [31:0] perf_mdu_cyc,
  output logic [31:0] perf_mem_cyc
`endif
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WLIM = WW'(MEM_TIMEOUT - 1);
  logic id_req, mem_wait;
  logic [WW-1:0] wcnt;
  assign id_req   = stallreq_id | stallreq_for_load;
  assign mem_wait = mem_req & ~mem_ready;
  // vectors nest, so the OR is the deepest requested stall
  assign stall = rst ? {6{NO_STOP}} :
                 (id_req ? STALL_ID_VEC : '0) |
                 (mdu_busy ? STALL_MDU_VEC : '0) |
                 (mem_wait ? STALL_MEM_VEC : '0);
  mdu_seq #(.MDU_LAT(MDU_LAT)) u_mdu (
    .clk      (clk),
    .rst      (rst),
    .mdu_start(mdu_start),
    .ex_stall (stall[3]),
    .mdu_busy (mdu_busy),
    .mdu_done (mdu_done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt        <= '0;
      mem_timeout <= 1'b0;
    end else begin
      wcnt        <= mem_wait ? (wcnt == WLIM ? wcnt : wcnt + 1'b1) : '0;
      mem_timeout <= mem_timeout | (mem_wait & wcnt == WLIM);
    end
  end
`ifdef STALL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_id_cyc  <= '0;
      perf_mdu_cyc <= '0;
      perf_mem_cyc <= '0;
    end else begin
      perf_id_cyc  <= perf_id_cyc + 32'(id_req);
      perf_mdu_cyc <= perf_mdu_cyc + 32'(mdu_busy);
      perf_mem_cyc <= perf_mem_cyc + 32'(mem_wait);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed checks of stall merge, MDU sequencing and MEM watchdog.
module tb_pipe_stall_ctrl;
  logic clk = 1'b0;
  logic rst, stallreq_id, stallreq_for_load, mdu_start, mem_req, mem_ready;
  logic [5:0] stall;
  logic mdu_busy, mdu_done, mem_timeout;
  int n_chk = 0;
  int n_fail = 0;

  pipe_stall_ctrl #(.MDU_LAT(4), .MEM_TIMEOUT(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_id      (stallreq_id),
    .stallreq_for_load(stallreq_for_load),
    .mdu_start        (mdu_start),
    .mem_req          (mem_req),
    .mem_ready        (mem_ready),
    .stall            (stall),
    .mdu_busy         (mdu_busy),
    .mdu_done         (mdu_done),
    .mem_timeout      (mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 1'b0; stallreq_for_load = 1'b1;
    mdu_start = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    tick; tick; #1;
    chk("rst_stall", 32'(stall), 32'h00);
    chk("rst_busy", 32'(mdu_busy), 32'h0);
    chk("rst_done", 32'(mdu_done), 32'h0);
    chk("rst_timeout", 32'(mem_timeout), 32'h0);
    tick; mdu_start = 1'b0;
    tick; rst = 1'b0; #1;
    chk("post_rst_stall", 32'(stall), 32'h1f);
    tick; stallreq_for_load = 1'b0; mem_req = 1'b0; #1;
    chk("idle_stall", 32'(stall), 32'h00);
    tick; stallreq_for_load = 1'b1; #1;
    chk("load_stall", 32'(stall), 32'h07);
    tick; stallreq_for_load = 1'b0; #1;
    chk("load_off", 32'(stall), 32'h00);
    tick; stallreq_id = 1'b1; #1;
    chk("id_stall", 32'(stall), 32'h07);
    tick; stallreq_id = 1'b0;
    // MDU alone: start held from t, stalls t..t+3, done at t+4
    tick; mdu_start = 1'b1; #1;
    chk("mdu_t0_stall", 32'(stall), 32'h0f);
    chk("mdu_t0_busy", 32'(mdu_busy), 32'h1);
    for (int i = 1; i < 4; i++) begin
      tick; #1;
      chk("mdu_busy_stall", 32'(stall), 32'h0f);
      chk("mdu_busy_done", 32'(mdu_done), 32'h0);
    end
    tick; #1;
    chk("mdu_t4_done", 32'(mdu_done), 32'h1);
    chk("mdu_t4_stall", 32'(stall), 32'h00);
    chk("mdu_t4_busy", 32'(mdu_busy), 32'h0);
    tick; mdu_start = 1'b0; #1;
    chk("mdu_t5_done", 32'(mdu_done), 32'h0);
    chk("mdu_t5_busy", 32'(mdu_busy), 32'h0);
    chk("mdu_t5_stall", 32'(stall), 32'h00);
    // new start right away proves the FSM is back in IDLE; MEM wait in t+3..t+6
    tick; mdu_start = 1'b1; #1;
    chk("mm_t0_busy", 32'(mdu_busy), 32'h1);
    chk("mm_t0_stall", 32'(stall), 32'h0f);
    tick; tick; #1;
    chk("mm_t2_stall", 32'(stall), 32'h0f);
    tick; mem_req = 1'b1; #1;
    chk("mm_t3_stall", 32'(stall), 32'h1f);
    chk("mm_t3_busy", 32'(mdu_busy), 32'h1);
    tick; #1;
    chk("mm_t4_stall", 32'(stall), 32'h1f);
    chk("mm_t4_done", 32'(mdu_done), 32'h1);
    tick; mdu_start = 1'b0; #1;
    chk("mm_t5_done", 32'(mdu_done), 32'h1);
    tick; #1;
    chk("mm_t6_stall", 32'(stall), 32'h1f);
    chk("mm_t6_done", 32'(mdu_done), 32'h1);
    tick; mem_req = 1'b0; #1;
    chk("mm_t7_stall", 32'(stall), 32'h00);
    chk("mm_t7_done", 32'(mdu_done), 32'h1);
    tick; #1;
    chk("mm_t8_done", 32'(mdu_done), 32'h0);
    chk("mm_t8_busy", 32'(mdu_busy), 32'h0);
    chk("mm_timeout", 32'(mem_timeout), 32'h0);
    // watchdog: 8 consecutive wait cycles
    for (int i = 1; i <= 8; i++) begin
      tick; mem_req = 1'b1; #1;
      chk("wd_wait_timeout", 32'(mem_timeout), 32'h0);
    end
    tick; mem_ready = 1'b1; #1;
    chk("wd_set", 32'(mem_timeout), 32'h1);
    chk("wd_ready_stall", 32'(stall), 32'h00);
    tick; mem_req = 1'b0; #1;
    chk("wd_sticky", 32'(mem_timeout), 32'h1);
    tick; rst = 1'b1;
    tick; rst = 1'b0; mem_ready = 1'b0; #1;
    chk("wd_clear", 32'(mem_timeout), 32'h0);
    // reset mid MDU sequence: no done afterwards
    tick; mdu_start = 1'b1;
    tick;
    tick; rst = 1'b1; #1;
    chk("mrst_stall", 32'(stall), 32'h00);
    chk("mrst_busy", 32'(mdu_busy), 32'h0);
    tick; rst = 1'b0; mdu_start = 1'b0; #1;
    chk("mrst_after_busy", 32'(mdu_busy), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick; #1;
      chk("mrst_no_done", 32'(mdu_done), 32'h0);
      chk("mrst_no_stall", 32'(stall), 32'h00);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
